ab_unit: RTL and testbench
==========================

AB_UNIT -- requirements
Module: ab_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  reset reset, synchronous, active-high; clock clk.
REQ-003 rdy  input  1  1 = advance; 0 = hold AB, PC and page_cross unchanged.
REQ-004 ab_op  input  13  address-bus op from ctl; fields [12:10] pc_op, [9:6] abh_sel, [5:3] abl_sel, [2:1] abl_src, [0] ci.
REQ-005 DB  input  8  data bus read value for the current cycle.
REQ-006 X, Y, S  input  8 each  index registers and stack pointer.
REQ-007 AB  output  16  registered address bus.
REQ-008 PC  output  16  registered program counter.
REQ-009 page_cross  output  1  registered ABL carry-out flag (present only per REQ-030).

Function
REQ-010 abl_src SHALL select the ABL base: 11 AB[7:0], 10 PC[7:0], 01 DB, 00 8'h00.
REQ-011 abl_sel SHALL select the ABL addend: 000 0, 001 X, 010 Y, 011 S, 100 FA, 101 FC, 110 FE, 111 DB.
REQ-012 ABL_next SHALL be bits [7:0] of the 9-bit sum base + addend + ci; carry c8 = bit 8.
REQ-013 abh_sel SHALL select ABH_next: 0000 00; 0110 01; 1100 FF; 1000 AB[15:8]+c8; 1001 AB[15:8]-1+c8; 1010 PC[15:8]+c8; 1011 DB+c8; all sums mod 256.
REQ-014 Undefined abh_sel codes SHALL produce ABH_next = AB[15:8] (hold).
REQ-015 AB_next = {ABH_next, ABL_next} SHALL be combinational from ab_op and inputs; no combinational path from ab_op to AB.
REQ-016 On a rising edge with rdy=1, AB SHALL load AB_next (latency 1 cycle).
REQ-017 pc_op[11]=0: PC SHALL hold.
REQ-018 pc_op[11]=1, [12]=0: PC SHALL load AB_next on the same edge as AB.
REQ-019 pc_op[11]=1, [12]=1: PC SHALL load current AB + pc_op[10] (16-bit, wraps FFFF->0000).
REQ-020 Address arithmetic SHALL wrap modulo 2^16 with no flag other than page_cross.
REQ-021 rdy=0 SHALL freeze all registers regardless of ab_op; rdy returning to 1 SHALL resume with the then-present ab_op.
REQ-022 No handshake or back-pressure beyond rdy; every rdy=1 cycle consumes exactly one ab_op.

Reset
REQ-023 reset SHALL take priority over rdy and ab_op.
REQ-024 On reset: AB = 16'hFFFC, PC = 16'h0000, page_cross = 0.
REQ-025 Reset asserted mid-sequence (e.g. branch or JSR) SHALL discard the pending operation; the first post-reset edge with rdy=1 SHALL use ab_op as presented.

Configuration
REQ-030 Macro AB_PAGE_CROSS_EN defined: page_cross SHALL register c8 on each rdy=1 edge, cleared by reset.
REQ-031 AB_PAGE_CROSS_EN undefined: page_cross port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-040 Reset: reset=1 one edge, rdy=0 -> AB=FFFC, PC=0000, page_cross=0.
REQ-041 Sequential fetch: AB=12FF, ab_op abl_src=11, abl_sel=000, ci=1, abh_sel=1000, pc_op=011 -> AB=PC=1300, page_cross=1.
REQ-042 Indexed zero page: DB=F0, X=20, abl_src=01, abl_sel=001, ci=0, abh_sel=0000, pc_op=000 -> AB=0010, PC unchanged.
REQ-043 Backward branch: AB=2005, DB=FA, abl_src=11, abl_sel=111, ci=1, abh_sel=1001 -> AB=2000; with AB=2001 -> AB=1FFC.
REQ-044 Stack and JSR save: S=FD, abl_src=00, abl_sel=011, ci=0, abh_sel=0110, pc_op=101, AB=4002 -> AB=01FD, PC=4002.
REQ-045 Stall and wrap: rdy=0 for 3 cycles with AB=FFFF, +1 op -> AB frozen; rdy=1 -> AB=0000, page_cross=1.

Source files
------------

// File: rtl/ab_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : ab_unit_if
// Purpose   : Control/data bundle between the sequencer and ab_unit.
//             Build macro AB_PAGE_CROSS_EN adds the page_cross flag.
// Revision  : 1.0  initial release
// ============================================================================
interface ab_unit_if;
  logic        rdy;
  logic [12:0] ab_op;
  logic [7:0]  DB;
  logic [7:0]  X;
  logic [7:0]  Y;
  logic [7:0]  S;
  logic [15:0] AB;
  logic [15:0] PC;
`ifdef AB_PAGE_CROSS_EN
  logic        page_cross;

  modport master (
    output rdy, ab_op, DB, X, Y, S,
    input  AB, PC, page_cross
  );

  modport slave (
    input  rdy, ab_op, DB, X, Y, S,
    output AB, PC, page_cross
  );
`else
  modport master (
    output rdy, ab_op, DB, X, Y, S,
    input  AB, PC
  );

  modport slave (
    input  rdy, ab_op, DB, X, Y, S,
    output AB, PC
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ab_unit.sv
`default_nettype none
// ============================================================================
// Module    : ab_unit
// Purpose   : Address-bus and program-counter datapath of an 8-bit CPU core.
//             Build macro AB_PAGE_CROSS_EN adds the registered page_cross flag.
// Revision  : 1.0  initial release
// ============================================================================
module ab_unit (
  input  wire logic clk,
  input  wire logic reset,
  ab_unit_if.slave  bus
);

  localparam logic [1:0] C_SRC_ZERO = 2'b00;
  localparam logic [1:0] C_SRC_DB   = 2'b01;
  localparam logic [1:0] C_SRC_PC   = 2'b10;
  localparam logic [1:0] C_SRC_AB   = 2'b11;

  localparam logic [2:0] C_ADD_ZERO = 3'b000;
  localparam logic [2:0] C_ADD_X    = 3'b001;
  localparam logic [2:0] C_ADD_Y    = 3'b010;
  localparam logic [2:0] C_ADD_S    = 3'b011;
  localparam logic [2:0] C_ADD_FA   = 3'b100;
  localparam logic [2:0] C_ADD_FC   = 3'b101;
  localparam logic [2:0] C_ADD_FE   = 3'b110;
  localparam logic [2:0] C_ADD_DB   = 3'b111;

  localparam logic [3:0] C_ABH_00     = 4'b0000;
  localparam logic [3:0] C_ABH_01     = 4'b0110;
  localparam logic [3:0] C_ABH_FF     = 4'b1100;
  localparam logic [3:0] C_ABH_AB     = 4'b1000;
  localparam logic [3:0] C_ABH_AB_DEC = 4'b1001;
  localparam logic [3:0] C_ABH_PC     = 4'b1010;
  localparam logic [3:0] C_ABH_DB     = 4'b1011;

  localparam logic [15:0] C_AB_RESET = 16'hFFFC;
  localparam logic [15:0] C_PC_RESET = 16'h0000;

  // ab_op field split
  logic [2:0] pc_op;
  logic [3:0] abh_sel;
  logic [2:0] abl_sel;
  logic [1:0] abl_src;
  logic       ci;

  assign pc_op   = bus.ab_op[12:10];
  assign abh_sel = bus.ab_op[9:6];
  assign abl_sel = bus.ab_op[5:3];
  assign abl_src = bus.ab_op[2:1];
  assign ci      = bus.ab_op[0];

  logic [7:0]  abl_base;
  logic [7:0]  abl_addend;
  logic [8:0]  abl_sum;
  logic        c8;
  logic [7:0]  abh_next;
  logic [15:0] ab_next;

  logic [15:0] ab_q;
  logic [15:0] ab_d;
  logic [15:0] pc_q;
  logic [15:0] pc_d;

  always_comb begin
    abl_base = 8'h00;
    unique case (abl_src)
      C_SRC_AB:   abl_base = ab_q[7:0];
      C_SRC_PC:   abl_base = pc_q[7:0];
      C_SRC_DB:   abl_base = bus.DB;
      C_SRC_ZERO: abl_base = 8'h00;
      default:    abl_base = 8'h00;
    endcase
  end

  always_comb begin
    abl_addend = 8'h00;
    unique case (abl_sel)
      C_ADD_ZERO: abl_addend = 8'h00;
      C_ADD_X:    abl_addend = bus.X;
      C_ADD_Y:    abl_addend = bus.Y;
      C_ADD_S:    abl_addend = bus.S;
      C_ADD_FA:   abl_addend = 8'hFA;
      C_ADD_FC:   abl_addend = 8'hFC;
      C_ADD_FE:   abl_addend = 8'hFE;
      C_ADD_DB:   abl_addend = bus.DB;
      default:    abl_addend = 8'h00;
    endcase
  end

  assign abl_sum = {1'b0, abl_base} + {1'b0, abl_addend} + {8'h00, ci};
  assign c8      = abl_sum[8];

  // High byte; the decrement form adds FF so that a carry from the low
  // byte cancels it (backward branch that stays on the same page).
  always_comb begin
    abh_next = ab_q[15:8];
    case (abh_sel)
      C_ABH_00:     abh_next = 8'h00;
      C_ABH_01:     abh_next = 8'h01;
      C_ABH_FF:     abh_next = 8'hFF;
      C_ABH_AB:     abh_next = ab_q[15:8] + {7'b0, c8};
      C_ABH_AB_DEC: abh_next = ab_q[15:8] + 8'hFF + {7'b0, c8};
      C_ABH_PC:     abh_next = pc_q[15:8] + {7'b0, c8};
      C_ABH_DB:     abh_next = bus.DB + {7'b0, c8};
      default:      abh_next = ab_q[15:8];
    endcase
  end

  assign ab_next = {abh_next, abl_sum[7:0]};

  always_comb begin
    ab_d = ab_q;
    pc_d = pc_q;
    if (bus.rdy) begin
      ab_d = ab_next;
      if (pc_op[1]) begin
        pc_d = pc_op[2] ? (ab_q + {15'b0, pc_op[0]}) : ab_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ab_q <= C_AB_RESET;
      pc_q <= C_PC_RESET;
    end else begin
      ab_q <= ab_d;
      pc_q <= pc_d;
    end
  end

  assign bus.AB = ab_q;
  assign bus.PC = pc_q;

`ifdef AB_PAGE_CROSS_EN
  logic page_cross_q;
  logic page_cross_d;

  always_comb begin
    page_cross_d = page_cross_q;
    if (bus.rdy) begin
      page_cross_d = c8;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page_cross_q <= 1'b0;
    end else begin
      page_cross_q <= page_cross_d;
    end
  end

  assign bus.page_cross = page_cross_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ab_unit.sv
`default_nettype none
// ============================================================================
// Module    : tb_ab_unit
// Purpose   : Directed and randomized checks of ab_unit against an
//             arithmetic reference model (honours AB_PAGE_CROSS_EN).
// Revision  : 1.0  initial release
// ============================================================================
module tb_ab_unit;

  logic clk = 1'b0;
  logic reset;

  ab_unit_if bus ();

  ab_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_ab;
  logic [15:0] m_pc;
  logic        m_pcx;

  function automatic logic [12:0] mk_op(int pc, int abh, int sel, int src, int ci);
    return {3'(pc), 4'(abh), 3'(sel), 2'(src), 1'(ci)};
  endfunction

  // Reference: the addressing rules evaluated with plain integer arithmetic.
  task automatic model_edge();
    int ab_i, pc_i, op, base, add, sum, lo, c8, hi, abh, nxt, pcop;
    if (reset) begin
      m_ab = 16'hFFFC; m_pc = 16'h0000; m_pcx = 1'b0;
      return;
    end
    if (!bus.rdy) return;
    op   = int'(bus.ab_op);
    ab_i = int'(m_ab);
    pc_i = int'(m_pc);
    pcop = (op >> 10) & 7;
    case ((op >> 1) & 3)
      3: base = ab_i % 256;
      2: base = pc_i % 256;
      1: base = int'(bus.DB);
      default: base = 0;
    endcase
    case ((op >> 3) & 7)
      1: add = int'(bus.X);
      2: add = int'(bus.Y);
      3: add = int'(bus.S);
      4: add = 'hFA;
      5: add = 'hFC;
      6: add = 'hFE;
      7: add = int'(bus.DB);
      default: add = 0;
    endcase
    sum = base + add + (op & 1);
    lo  = sum % 256;
    c8  = sum / 256;
    hi  = ab_i / 256;
    case ((op >> 6) & 15)
      0:  abh = 0;
      6:  abh = 1;
      12: abh = 255;
      8:  abh = (hi + c8) % 256;
      9:  abh = (hi - 1 + c8 + 256) % 256;
      10: abh = (pc_i / 256 + c8) % 256;
      11: abh = (int'(bus.DB) + c8) % 256;
      default: abh = hi;
    endcase
    nxt = abh * 256 + lo;
    if ((pcop & 2) != 0)
      m_pc = ((pcop & 4) != 0) ? 16'((ab_i + (pcop & 1)) % 65536) : 16'(nxt);
    m_ab  = 16'(nxt);
    m_pcx = (c8 != 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(int hi, int lo);
    bus.rdy   = 1'b1;
    bus.DB    = 8'(hi);
    bus.ab_op = mk_op(0, 'b1011, 0, 1, 0);
    step();
    bus.DB    = 8'(lo);
    bus.ab_op = mk_op(0, 'b1000, 0, 1, 0);
    step();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.rdy   = 1'b0;
    bus.ab_op = 13'($urandom);
    step();
    n_checks++;
    if (bus.AB !== 16'hFFFC) $display("FAIL reset_ab: got %h want %h", bus.AB, 16'hFFFC);
    else n_pass++;
    n_checks++;
    if (bus.PC !== 16'h0000) $display("FAIL reset_pc: got %h want %h", bus.PC, 16'h0000);
    else n_pass++;
`ifdef AB_PAGE_CROSS_EN
    n_checks++;
    if (bus.page_cross !== 1'b0) $display("FAIL reset_pcx: got %b want 0", bus.page_cross);
    else n_pass++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    set_ab('h12, 'hFF);
    bus.ab_op = mk_op('b011, 'b1000, 0, 3, 1);
    step();
    n_checks++;
    if (bus.AB !== 16'h1300) $display("FAIL fetch_ab: got %h want %h", bus.AB, 16'h1300);
    else n_pass++;
    n_checks++;
    if (bus.PC !== 16'h1300) $display("FAIL fetch_pc: got %h want %h", bus.PC, 16'h1300);
    else n_pass++;
`ifdef AB_PAGE_CROSS_EN
    n_checks++;
    if (bus.page_cross !== 1'b1) $display("FAIL fetch_pcx: got %b want 1", bus.page_cross);
    else n_pass++;
`endif
  endtask

  task automatic test_zero_page();
    bus.DB    = 8'hF0;
    bus.X     = 8'h20;
    bus.ab_op = mk_op(0, 'b0000, 1, 1, 0);
    step();
    n_checks++;
    if (bus.AB !== 16'h0010) $display("FAIL zp_ab: got %h want %h", bus.AB, 16'h0010);
    else n_pass++;
    n_checks++;
    if (bus.PC !== 16'h1300) $display("FAIL zp_pc: got %h want %h", bus.PC, 16'h1300);
    else n_pass++;
  endtask

  task automatic test_branch();
    set_ab('h20, 'h05);
    bus.DB    = 8'hFA;
    bus.ab_op = mk_op(0, 'b1001, 7, 3, 1);
    step();
    n_checks++;
    if (bus.AB !== 16'h2000) $display("FAIL branch_same_page: got %h want %h", bus.AB, 16'h2000);
    else n_pass++;
    set_ab('h20, 'h01);
    bus.DB    = 8'hFA;
    bus.ab_op = mk_op(0, 'b1001, 7, 3, 1);
    step();
    n_checks++;
    if (bus.AB !== 16'h1FFC) $display("FAIL branch_cross: got %h want %h", bus.AB, 16'h1FFC);
    else n_pass++;
`ifdef AB_PAGE_CROSS_EN
    n_checks++;
    if (bus.page_cross !== 1'b0) $display("FAIL branch_pcx: got %b want 0", bus.page_cross);
    else n_pass++;
`endif
  endtask

  task automatic test_jsr();
    set_ab('h40, 'h02);
    bus.ab_op = mk_op('b110, 'b0001, 0, 3, 0);
    step();
    n_checks++;
    if (bus.PC !== 16'h4002) $display("FAIL pc_from_ab: got %h want %h", bus.PC, 16'h4002);
    else n_pass++;
    bus.S     = 8'hFD;
    bus.ab_op = mk_op('b101, 'b0110, 3, 0, 0);
    step();
    n_checks++;
    if (bus.AB !== 16'h01FD) $display("FAIL jsr_ab: got %h want %h", bus.AB, 16'h01FD);
    else n_pass++;
    n_checks++;
    if (bus.PC !== 16'h4002) $display("FAIL jsr_pc: got %h want %h", bus.PC, 16'h4002);
    else n_pass++;
    bus.ab_op = mk_op('b111, 'b0001, 0, 3, 0);
    step();
    n_checks++;
    if (bus.PC !== 16'h01FE) $display("FAIL pc_ab_inc: got %h want %h", bus.PC, 16'h01FE);
    else n_pass++;
  endtask

  task automatic test_stall_wrap();
    set_ab('hFF, 'hFF);
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ab_op = 13'($urandom);
      bus.DB    = 8'($urandom);
      step();
      n_checks++;
      if (bus.AB !== 16'hFFFF) $display("FAIL stall_ab[%0d]: got %h want %h", i, bus.AB, 16'hFFFF);
      else n_pass++;
    end
    bus.ab_op = mk_op('b111, 'b1000, 0, 3, 1);
    bus.rdy   = 1'b1;
    step();
    n_checks++;
    if (bus.AB !== 16'h0000) $display("FAIL wrap_ab: got %h want %h", bus.AB, 16'h0000);
    else n_pass++;
    n_checks++;
    if (bus.PC !== 16'h0000) $display("FAIL wrap_pc: got %h want %h", bus.PC, 16'h0000);
    else n_pass++;
`ifdef AB_PAGE_CROSS_EN
    n_checks++;
    if (bus.page_cross !== 1'b1) $display("FAIL wrap_pcx: got %b want 1", bus.page_cross);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    set_ab('h20, 'h05);
    bus.DB    = 8'hFA;
    bus.ab_op = mk_op('b011, 'b1001, 7, 3, 1);
    reset     = 1'b1;
    step();
    n_checks++;
    if (bus.AB !== 16'hFFFC) $display("FAIL mid_reset_ab: got %h want %h", bus.AB, 16'hFFFC);
    else n_pass++;
    reset     = 1'b0;
    bus.ab_op = mk_op('b011, 'b1000, 0, 3, 1);
    step();
    n_checks++;
    if (bus.AB !== 16'hFFFD) $display("FAIL post_reset_ab: got %h want %h", bus.AB, 16'hFFFD);
    else n_pass++;
    n_checks++;
    if (bus.PC !== 16'hFFFD) $display("FAIL post_reset_pc: got %h want %h", bus.PC, 16'hFFFD);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.ab_op = 13'($urandom);
      bus.DB    = 8'($urandom);
      bus.X     = 8'($urandom);
      bus.Y     = 8'($urandom);
      bus.S     = 8'($urandom);
      bus.rdy   = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 39) == 0);
      step();
      n_checks++;
      if (bus.AB !== m_ab) $display("FAIL rand_ab[%0d]: got %h want %h", i, bus.AB, m_ab);
      else n_pass++;
      n_checks++;
      if (bus.PC !== m_pc) $display("FAIL rand_pc[%0d]: got %h want %h", i, bus.PC, m_pc);
      else n_pass++;
`ifdef AB_PAGE_CROSS_EN
      n_checks++;
      if (bus.page_cross !== m_pcx) $display("FAIL rand_pcx[%0d]: got %b want %b", i, bus.page_cross, m_pcx);
      else n_pass++;
`endif
    end
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.rdy   = 1'b0;
    bus.ab_op = '0;
    bus.DB    = '0;
    bus.X     = '0;
    bus.Y     = '0;
    bus.S     = '0;
    m_ab      = 16'hFFFC;
    m_pc      = 16'h0000;
    m_pcx     = 1'b0;
    #2;
    test_reset();
    test_fetch();
    test_zero_page();
    test_branch();
    test_jsr();
    test_stall_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
